// File: rtl/lifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// lifo_arb_pkg
// Shared types and constants for the lifo_arbiter block.
//   state_t : arbiter FSM encoding (ARB -> EXEC -> RESP -> ARB)
//   OP_PUSH / OP_POP : encoding of the per-requester req_op bit
// -----------------------------------------------------------------------------
package lifo_arb_pkg;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

endpackage

// File: rtl/lifo_arbiter_if.sv
// -----------------------------------------------------------------------------
// lifo_arbiter_if
// Requester-side request/response bundle of the lifo_arbiter.
//   req_valid/req_op/req_data : per-requester op request (driven by clients)
//   req_ready                 : one-hot accept pulse (driven by arbiter)
//   rsp_valid/rsp_data/rsp_err: one-hot response pulse + shared payload
// Modports: master = client engines side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface lifo_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_op;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_err;

    modport master (
        output req_valid, req_op, req_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_data,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating picker: returns the first set bit of i_valid found
// by searching upward from i_ptr with wrap-around.
//   i_valid [NREQ]  candidate requests
//   i_ptr   [IDXW]  search start index (tie to 0 for fixed priority)
//   o_grant [NREQ]  one-hot grant (all zero when no request)
//   o_idx   [IDXW]  binary index of the granted requester
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IDXW-1:0] i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDXW-1:0] o_idx
);

    logic w_found;

    // Walk the candidates in rotated order; the first valid one wins.
    always_comb begin
        int   j;
        logic w_take;
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j       = (int'(i_ptr) + k) % NREQ;
            w_take  = !w_found && i_valid[IDXW'(j)];
            o_grant[IDXW'(j)] = w_take;
            o_idx   = w_take ? IDXW'(j) : o_idx;
            w_found = w_found | w_take;
        end
    end

endmodule

// File: rtl/lifo_arbiter.sv
// -----------------------------------------------------------------------------
// lifo_arbiter
// Serialises push/pop ops from NREQ requesters onto one lifo_ctl stack.
// Each op takes three cycles: ARB (accept, req_ready pulse), EXEC (stack
// strobe, full/empty sampled), RESP (registered rsp_valid/rsp_data/rsp_err).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   bus (slave)         requester request/response bundle (lifo_arbiter_if)
//   stk_push/stk_pop    strobes to lifo_ctl (only ever asserted in EXEC)
//   stk_din             push data to lifo_ctl
//   stk_dout            lifo_ctl top-of-stack (combinational)
//   stk_empty/stk_full  lifo_ctl status flags
// Configuration:
//   LIFO_ARB_FIXED_PRIO_EN : lowest index always wins, no round-robin pointer.
// -----------------------------------------------------------------------------
module lifo_arbiter
    import lifo_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    lifo_arbiter_if.slave    bus,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [WIDTH-1:0] stk_din,
    input  logic [WIDTH-1:0] stk_dout,
    input  logic             stk_empty,
    input  logic             stk_full
);

    localparam int IDXW = $clog2(NREQ);

    // DEPTH lives in lifo_ctl; it is only sanity-checked here.
    if (NREQ < 2 || NREQ > 8 || WIDTH < 1 || DEPTH < 1) begin : g_bad_cfg
        $error("lifo_arbiter: unsupported parameter set");
    end

    state_t            r_state;
    state_t            w_next_state;
    logic [IDXW-1:0]   r_idx;
    logic              r_op;
    logic [WIDTH-1:0]  r_data;
    logic [NREQ-1:0]   r_rsp_valid;
    logic [WIDTH-1:0]  r_rsp_data;
    logic              r_rsp_err;
    logic [NREQ-1:0]   w_grant;
    logic [IDXW-1:0]   w_idx;
    logic [IDXW-1:0]   w_ptr;
    logic              w_push_ok;
    logic              w_pop_ok;

`ifdef LIFO_ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [IDXW-1:0] r_rr_ptr;
    assign w_ptr = r_rr_ptr;
`endif

    rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
        .i_valid (bus.req_valid),
        .i_ptr   (w_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    // Legal stack ops, only meaningful while in EXEC.
    assign w_push_ok = (r_state == EXEC) && (r_op == OP_PUSH) && !stk_full;
    assign w_pop_ok  = (r_state == EXEC) && (r_op == OP_POP)  && !stk_empty;

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus accept pulse and stack strobes.
    always_comb begin
        w_next_state  = r_state;
        bus.req_ready = '0;
        stk_push      = 1'b0;
        stk_pop       = 1'b0;
        stk_din       = '0;
        case (r_state)
            ARB: begin
                bus.req_ready = w_grant;
                if (|bus.req_valid) begin
                    w_next_state = EXEC;
                end else begin
                    w_next_state = ARB;
                end
            end
            EXEC: begin
                stk_push     = w_push_ok;
                stk_pop      = w_pop_ok;
                stk_din      = w_push_ok ? r_data : '0;
                w_next_state = RESP;
            end
            RESP: begin
                w_next_state = ARB;
            end
            default: begin
                w_next_state = ARB;
            end
        endcase
    end

    // Op latch, response registers and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_op        <= 1'b0;
            r_data      <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
`ifndef LIFO_ARB_FIXED_PRIO_EN
            r_rr_ptr    <= '0;
`endif
        end else begin
            case (r_state)
                ARB: begin
                    if (|bus.req_valid) begin
                        r_idx  <= w_idx;
                        r_op   <= bus.req_op[w_idx];
                        r_data <= bus.req_data[int'(w_idx)*WIDTH +: WIDTH];
                    end
                end
                EXEC: begin
                    // Pop data is captured on the same edge the stack pops.
                    r_rsp_valid <= {{(NREQ-1){1'b0}}, 1'b1} << r_idx;
                    r_rsp_data  <= w_pop_ok ? stk_dout : '0;
                    r_rsp_err   <= !(w_push_ok || w_pop_ok);
                end
                RESP: begin
                    r_rsp_valid <= '0;
`ifndef LIFO_ARB_FIXED_PRIO_EN
                    r_rr_ptr    <= (r_idx == IDXW'(NREQ - 1)) ? '0 : r_idx + IDXW'(1);
`endif
                end
                default: begin
                    r_rsp_valid <= '0;
                end
            endcase
        end
    end

endmodule
